// File: rtl/sd_spi_cmd_engine.sv
// SPI-mode SD command engine: sends a 48-bit command frame on DI, optionally
// collects an R1 or R3/R7 response from DO with an NCR timeout, then clocks
// TAIL_BITS idle bits with CS deasserted.
module sd_spi_cmd_engine #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned NCR_MAX   = 8,
  parameter int unsigned TAIL_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  index,
  input  logic [31:0] argument,
  input  logic [1:0]  respLen,
  input  logic        isStart,
  output logic        isBusy,
  output logic        isFinish,
  output logic        isTimeout,
  output logic [39:0] response,
  output logic        SCLK,
  output logic        CS,
  output logic        DI,
  input  logic        DO
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned NCR_BITS = NCR_MAX * 8;
  localparam int unsigned CNT_MAX0 = (NCR_BITS > 48) ? NCR_BITS : 48;
  localparam int unsigned CNT_MAX  = (TAIL_BITS > CNT_MAX0) ? TAIL_BITS : CNT_MAX0;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_RECV, S_TAIL, S_DONE
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             phase;     // 0: SCLK low half, 1: SCLK high half
  logic [CNT_W-1:0] bit_cnt;
  logic [47:0]      tx_sr;
  logic             long_r;    // 40-bit response expected
  logic             none_r;    // no response expected
  logic             do_bit;    // DO sampled at the SCLK rising edge
  logic [47:0]      frame_c;
  logic             tick_c;
  logic             bit_end_c;
  logic [CNT_W-1:0] rx_last_c;

  // CRC7 (x^7 + x^3 + 1, init 0) over the first 40 frame bits, MSB first
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Frame assembled from the live inputs; only used at start acceptance
  always_comb begin
    frame_c = {2'b01, index, argument, crc7({2'b01, index, argument}), 1'b1};
  end

  // Divider tick, end-of-bit strobe and last receive bit index
  always_comb begin
    tick_c    = (div_cnt == DIV_W'(CLK_DIV - 1));
    bit_end_c = tick_c && phase;
    rx_last_c = long_r ? CNT_W'(39) : CNT_W'(7);
  end

  // Command FSM with SCLK generation and registered pin/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_cnt   <= '0;
      tx_sr     <= '1;
      long_r    <= 1'b0;
      none_r    <= 1'b0;
      do_bit    <= 1'b1;
      isBusy    <= 1'b0;
      isFinish  <= 1'b0;
      isTimeout <= 1'b0;
      response  <= '0;
      SCLK      <= 1'b0;
      CS        <= 1'b1;
      DI        <= 1'b1;
    end else begin
      if (state inside {S_SEND, S_WAIT, S_RECV, S_TAIL}) begin
        if (tick_c) begin
          div_cnt <= '0;
          phase   <= ~phase;
          SCLK    <= ~phase;
          if (!phase) do_bit <= DO;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (isStart) begin
            tx_sr     <= {frame_c[46:0], 1'b1};
            DI        <= frame_c[47];
            CS        <= 1'b0;
            isBusy    <= 1'b1;
            response  <= '0;
            isTimeout <= 1'b0;
            long_r    <= (respLen == 2'd2);
            none_r    <= (respLen == 2'd0);
            bit_cnt   <= '0;
            div_cnt   <= '0;
            phase     <= 1'b0;
            SCLK      <= 1'b0;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (bit_end_c) begin
            if (bit_cnt == CNT_W'(47)) begin
              bit_cnt <= '0;
              DI      <= 1'b1;
              if (none_r) begin
                CS    <= 1'b1;
                state <= S_TAIL;
              end else begin
                state <= S_WAIT;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              DI      <= tx_sr[47];
              tx_sr   <= {tx_sr[46:0], 1'b1};
            end
          end
        end
        S_WAIT: begin
          if (bit_end_c) begin
            if (!do_bit) begin
              response <= {response[38:0], 1'b0};
              bit_cnt  <= CNT_W'(1);
              state    <= S_RECV;
            end else if (bit_cnt == CNT_W'(NCR_BITS - 1)) begin
              isTimeout <= 1'b1;
              response  <= long_r ? 40'hFF_FFFF_FFFF : 40'h00_0000_00FF;
              bit_cnt   <= '0;
              CS        <= 1'b1;
              state     <= S_TAIL;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_RECV: begin
          if (bit_end_c) begin
            response <= {response[38:0], do_bit};
            if (bit_cnt == rx_last_c) begin
              bit_cnt <= '0;
              CS      <= 1'b1;
              state   <= S_TAIL;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_TAIL: begin
          if (bit_end_c) begin
            if (bit_cnt == CNT_W'(TAIL_BITS - 1)) begin
              bit_cnt  <= '0;
              isBusy   <= 1'b0;
              isFinish <= 1'b1;
              state    <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          if (!isStart) begin
            isFinish <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// Self-checking bench for sd_spi_cmd_engine with a behavioural SD card on DO.
module tb_sd_spi_cmd_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  index;
  logic [31:0] argument;
  logic [1:0]  respLen;
  logic        isStart;
  logic        isBusy, isFinish, isTimeout;
  logic [39:0] response;
  logic        SCLK, CS, DI;
  logic        DO = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  // card / monitor state
  int          c_ncr   = 0;
  int          c_len   = 0;
  logic [39:0] c_resp  = '0;
  bit          c_stuck = 1'b0;
  int          rise_cnt    = 0;
  int          total_rises = 0;
  int          tail_rises  = 0;
  int          tail_di_bad = 0;
  logic [47:0] frame_cap   = '0;

  typedef struct {
    logic [7:0]  idx;
    logic [31:0] arg;
    logic [1:0]  rlen;
    int          ncr;
    int          clen;
    logic [39:0] cresp;
    bit          stuck;
    logic [47:0] exp_frame;
    logic [39:0] exp_resp;
    bit          exp_to;
    int          exp_rises;
  } vec_t;

  typedef struct {
    logic [47:0] frame;
    logic [39:0] resp;
    bit          to;
    int          rises;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  sd_spi_cmd_engine #(.CLK_DIV(1), .NCR_MAX(8), .TAIL_BITS(8)) dut (
    .clk(clk), .rst(rst), .index(index), .argument(argument), .respLen(respLen),
    .isStart(isStart), .isBusy(isBusy), .isFinish(isFinish), .isTimeout(isTimeout),
    .response(response), .SCLK(SCLK), .CS(CS), .DI(DI), .DO(DO)
  );

  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  // Bit-level monitor: frame capture and SCLK counting per transaction
  always @(posedge SCLK or negedge CS) begin
    if (SCLK) begin
      total_rises = total_rises + 1;
      if (!CS) begin
        if (rise_cnt < 48) frame_cap = {frame_cap[46:0], DI};
        rise_cnt = rise_cnt + 1;
      end else begin
        tail_rises = tail_rises + 1;
        if (DI !== 1'b1) tail_di_bad = tail_di_bad + 1;
      end
    end else begin
      rise_cnt    = 0;
      total_rises = 0;
      tail_rises  = 0;
      tail_di_bad = 0;
    end
  end

  function automatic logic card_bit(input int k, input int ncr, input int len,
                                    input logic [39:0] r, input bit stuck);
    int j;
    if (k < 48 || stuck) return 1'b1;
    j = k - 48;
    if (j < ncr * 8) return 1'b1;
    j = j - ncr * 8;
    if (j < len) return r[len - 1 - j];
    return 1'b1;
  endfunction

  // Card drives the next bit after each SCLK falling edge (mode 0)
  always @(negedge SCLK or posedge CS) begin
    if (CS) DO <= 1'b1;
    else    DO <= card_bit(rise_cnt, c_ncr, c_len, c_resp, c_stuck);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one transaction; hold isStart for 'hold' cycles after isFinish
  task automatic run_vec(input vec_t v, input int hold);
    exp_t e;
    bit   done;
    int   r0;
    index    = v.idx[5:0];
    argument = v.arg;
    respLen  = v.rlen;
    c_ncr    = v.ncr;
    c_len    = v.clen;
    c_resp   = v.cresp;
    c_stuck  = v.stuck;
    sb.push_back('{frame: v.exp_frame, resp: v.exp_resp, to: v.exp_to, rises: v.exp_rises});
    isStart = 1'b1;
    tick();
    check("busy_after_start", 64'(isBusy), 64'(1));
    check("cs_after_start", 64'(CS), 64'(0));
    check("resp_cleared", 64'(response), 64'(0));
    check("timeout_cleared", 64'(isTimeout), 64'(0));
    index    = 6'($urandom);
    argument = $urandom;
    respLen  = 2'($urandom);
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      tick();
      if (isFinish) done = 1'b1;
    end
    check("finish_seen", 64'(isFinish), 64'(1));
    e = sb.pop_front();
    check("frame", 64'(frame_cap), 64'(e.frame));
    check("response", 64'(response), 64'(e.resp));
    check("timeout", 64'(isTimeout), 64'(e.to));
    check("sclk_rises", 64'(total_rises), 64'(e.rises));
    check("tail_rises", 64'(tail_rises), 64'(8));
    check("tail_di_high", 64'(tail_di_bad), 64'(0));
    check("done_not_busy", 64'(isBusy), 64'(0));
    check("done_cs_high", 64'({SCLK, CS}), 64'(2'b01));
    if (hold > 0) begin
      r0 = total_rises;
      repeat (hold) tick();
      check("hold_finish", 64'(isFinish), 64'(1));
      check("hold_no_retrigger", 64'(total_rises), 64'(r0));
      check("hold_not_busy", 64'(isBusy), 64'(0));
    end
    isStart = 1'b0;
    tick();
    check("finish_drop", 64'(isFinish), 64'(0));
    check("resp_held", 64'(response), 64'(e.resp));
  endtask

  initial begin
    bit hit;
    //            idx    arg           rl ncr len cresp            stuck frame                    resp              to rises
    vecs[0] = '{8'h00, 32'h0000_0000, 2'd0, 0, 0,  40'h0,           0, 48'h40_0000_0000_95, 40'h0,            0, 56};
    vecs[1] = '{8'h08, 32'h0000_01AA, 2'd2, 2, 40, 40'h01_0000_01AA, 0, 48'h48_0000_01AA_87, 40'h01_0000_01AA, 0, 112};
    vecs[2] = '{8'h77, 32'h0000_0000, 2'd1, 1, 8,  40'h01,          0, 48'h77_0000_0000_65, 40'h01,           0, 72};
    vecs[3] = '{8'h3A, 32'h0000_0000, 2'd3, 0, 8,  40'h01,          0, 48'h7A_0000_0000_FD, 40'h01,           0, 64};
    vecs[4] = '{8'h01, 32'h0000_0000, 2'd1, 0, 8,  40'h0,           1, 48'h41_0000_0000_F9, 40'hFF,           1, 120};
    vecs[5] = '{8'h08, 32'h0000_01AA, 2'd2, 0, 40, 40'h0,           1, 48'h48_0000_01AA_87, 40'hFF_FFFF_FFFF, 1, 120};

    rst = 1'b1; isStart = 1'b0; index = '0; argument = '0; respLen = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_pins", 64'({SCLK, CS, DI}), 64'(3'b011));
    check("rst_status", 64'({isBusy, isFinish, isTimeout}), 64'(3'b000));
    check("rst_response", 64'(response), 64'(0));

    foreach (vecs[i]) run_vec(vecs[i], 0);

    // Reset in the middle of a SEND frame
    index = 6'h11; argument = 32'hDEAD_BEEF; respLen = 2'd1;
    isStart = 1'b1;
    tick();
    isStart = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      tick();
      if (rise_cnt >= 20) hit = 1'b1;
    end
    check("reached_bit20", 64'(hit), 64'(1));
    rst = 1'b1;
    tick();
    check("midrst_pins", 64'({SCLK, CS, DI}), 64'(3'b011));
    check("midrst_busy", 64'(isBusy), 64'(0));
    rst = 1'b0;
    tick();
    run_vec(vecs[0], 0);

    // isStart held through DONE must not start a second transaction
    run_vec(vecs[2], 20);
    run_vec(vecs[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
